piso_tx: RTL and testbench
==========================

PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, legal range 2..32.
REQ-002 Parameter PARITY_EN, default 0: 1 inserts an even-parity bit after the data bits.
REQ-003 Parameter IDLE_LEVEL, default 1: line level while idle and during the stop bit.
REQ-004 clock  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 data_in  input  WIDTH  parallel word to transmit.
REQ-007 data_valid  input  1  data_in is valid this cycle.
REQ-008 data_ready  output  1  block can accept a word this cycle.
REQ-009 serial_out  output  1  registered serial line, one bit per clock.
REQ-010 busy  output  1  high while a word is buffered or a frame is in progress.
REQ-011 done  output  1  one-cycle pulse marking completion of a frame.

Function
REQ-012 Frame format SHALL be, in order:
- start bit = ~IDLE_LEVEL;
- WIDTH data bits, LSB first;
- parity bit if PARITY_EN, equal to XOR of all data bits (even parity);
- one stop bit = IDLE_LEVEL.
REQ-013 Frame length SHALL be WIDTH+2+PARITY_EN clock cycles, each bit held exactly one cycle.
REQ-014 The block SHALL contain a one-word holding register (hold) and a shift register feeding serial_out.
REQ-015 data_ready SHALL equal ~hold_full, with no combinational path from data_valid.
REQ-016 A word SHALL be accepted on the rising edge where data_valid and data_ready are both high; it is copied into hold and hold_full sets.
REQ-017 While data_ready is low, data_valid and data_in SHALL be ignored; upstream holds them stable.
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE -> START on the edge after hold_full is seen: hold moves into the shift register and hold_full clears, unless a new accept happens on the same edge, in which case hold_full stays set with the new word.
REQ-020 START -> DATA after 1 cycle.
REQ-021 DATA SHALL shift right, driving shift[0], and use a bit counter from 0 to WIDTH-1.
REQ-022 DATA -> PARITY, or -> STOP if PARITY_EN=0, after WIDTH cycles.
REQ-023 PARITY -> STOP after 1 cycle.
REQ-024 STOP SHALL go -> START if hold_full (back-to-back frames, zero idle cycles, hold transferred as in REQ-019), else -> IDLE.
REQ-025 Latency: a word accepted at edge k while in IDLE with hold empty SHALL put the start bit on serial_out from edge k+2 (edge k+1 loads START; serial_out is registered).
REQ-026 Parity SHALL be computed from the word as loaded into the shift register, not from live data_in.
REQ-027 done SHALL be high exactly during the cycle serial_out drives the stop bit, once per frame.
REQ-028 busy SHALL be high whenever the state is not IDLE or hold_full=1.
REQ-029 serial_out SHALL be IDLE_LEVEL in IDLE.

Reset
REQ-030 While reset is asserted, and immediately on assertion regardless of clock:
- state=IDLE, hold_full=0, counter=0, shift register=0;
- serial_out=IDLE_LEVEL, done=0, busy=0, data_ready=1.
REQ-031 Reset mid-frame SHALL abort the frame and discard the buffered word; no done pulse is issued for it.
REQ-032 After reset deasserts, the first accept SHALL follow the REQ-025 timing.

Verification (WIDTH=8, IDLE_LEVEL=1 unless stated)
REQ-033 Single word 0xA5, PARITY_EN=0 -> serial_out 0,1,0,1,0,0,1,0,1,1, then 1 (idle); done high on the 10th bit only; busy high from the accept edge to the stop-bit cycle.
REQ-034 PARITY_EN=1, word 0x07 -> 0,1,1,1,0,0,0,0,0,1(parity),1(stop); frame is 11 cycles.
REQ-035 Words 0x01 then 0x80, data_valid held high -> second start bit immediately follows the first stop bit; done pulses 10 cycles apart.
REQ-036 Backpressure: data_valid high continuously with 3 words -> data_ready low while hold is full; every word is sent exactly once, in order.
REQ-037 reset pulsed during data bit 4 of 0x3C with 0x55 buffered -> serial_out=1 immediately, data_ready=1, no done pulse, no further frame.
REQ-038 IDLE_LEVEL=0, word 0xFF -> start bit 1, eight 1s, stop bit 0; line stays 0 afterwards.

Source files
------------

// File: rtl/piso_tx_if.sv
// Parallel-in / serial-out transmitter bus: word handshake in, serial line and status out.
interface piso_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             serial_out;
  logic             busy;
  logic             done;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  serial_out,
    input  busy,
    input  done
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output serial_out,
    output busy,
    output done
  );
endinterface

// File: rtl/piso_tx.sv
// Serial transmitter: one-word holding register feeding a shift register.
// Frame: start (~IDLE_LEVEL), WIDTH data bits LSB first, optional even parity,
// stop (IDLE_LEVEL). serial_out and done are registered, so the line trails the FSM
// state by one cycle.
module piso_tx #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          IDLE_LEVEL = 1'b1
) (
  input  logic     clk_i,
  input  logic     rst_i,
  piso_tx_if.slave tx_io
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             parity_q, parity_d;
  logic             serial_q, serial_d;
  logic             done_q, done_d;
  logic             accept;
  logic             load;

  // data_ready depends only on registered state, never on data_valid.
  assign accept = tx_io.data_valid & ~hold_full_q;

  // Frame sequencing; serial_d/done_d describe the bit the line shows next cycle.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    parity_d = parity_q;
    serial_d = IDLE_LEVEL;
    done_d   = 1'b0;
    load     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        serial_d = ~IDLE_LEVEL;
        state_d  = StData;
      end
      StData: begin
        serial_d = shift_q[0];
        shift_d  = shift_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = PARITY_EN ? StParity : StStop;
        end
      end
      StParity: begin
        serial_d = parity_q;
        state_d  = StStop;
      end
      StStop: begin
        serial_d = IDLE_LEVEL;
        done_d   = 1'b1;
        // Back-to-back frames: a buffered word starts with no idle gap.
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = StStart;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Parity is taken from the word as it enters the shift register.
    if (load) begin
      shift_d  = hold_q;
      parity_d = ^hold_q;
      cnt_d    = '0;
    end
  end

  // Holding register: accept only when empty, so accept and load never coincide.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (load) begin
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_d      = tx_io.data_in;
      hold_full_d = 1'b1;
    end
  end

  // State and datapath registers with asynchronous reset to an idle line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      parity_q    <= 1'b0;
      serial_q    <= IDLE_LEVEL;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      parity_q    <= parity_d;
      serial_q    <= serial_d;
      done_q      <= done_d;
    end
  end

  assign tx_io.data_ready = ~hold_full_q;
  assign tx_io.serial_out = serial_q;
  assign tx_io.done       = done_q;
  // done_q keeps busy high while the stop bit is still on the line.
  assign tx_io.busy       = (state_q != StIdle) | hold_full_q | done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: three configurations (plain, parity, inverted idle) share clock and
// reset. Drivers push accepted words into per-instance scoreboards; a monitor rebuilds
// each expected frame from the word and compares the line bit by bit.
module tb_piso_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  logic       vld [3];
  logic [7:0] din [3];
  logic       ser [3];
  logic       rdy [3];
  logic       bsy [3];
  logic       dn  [3];

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] sb0[$];
  logic [7:0] sb1[$];
  logic [7:0] sb2[$];
  int         pos [3];
  logic [7:0] cur [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  piso_tx_if #(.WIDTH(8)) if0 ();
  piso_tx_if #(.WIDTH(8)) if1 ();
  piso_tx_if #(.WIDTH(8)) if2 ();

  piso_tx #(.WIDTH(8), .PARITY_EN(1'b0), .IDLE_LEVEL(1'b1)) dut0 (
    .clk_i(clk), .rst_i(rst), .tx_io(if0)
  );
  piso_tx #(.WIDTH(8), .PARITY_EN(1'b1), .IDLE_LEVEL(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .tx_io(if1)
  );
  piso_tx #(.WIDTH(8), .PARITY_EN(1'b0), .IDLE_LEVEL(1'b0)) dut2 (
    .clk_i(clk), .rst_i(rst), .tx_io(if2)
  );

  assign if0.data_valid = vld[0];
  assign if0.data_in    = din[0];
  assign if1.data_valid = vld[1];
  assign if1.data_in    = din[1];
  assign if2.data_valid = vld[2];
  assign if2.data_in    = din[2];
  assign ser[0] = if0.serial_out;
  assign ser[1] = if1.serial_out;
  assign ser[2] = if2.serial_out;
  assign rdy[0] = if0.data_ready;
  assign rdy[1] = if1.data_ready;
  assign rdy[2] = if2.data_ready;
  assign bsy[0] = if0.busy;
  assign bsy[1] = if1.busy;
  assign bsy[2] = if2.busy;
  assign dn[0]  = if0.done;
  assign dn[1]  = if1.done;
  assign dn[2]  = if2.done;

  // Per-instance configuration of the reference model.
  function automatic logic idl(int i);
    return (i == 2) ? 1'b0 : 1'b1;
  endfunction

  function automatic int par(int i);
    return (i == 1) ? 1 : 0;
  endfunction

  function automatic int flen(int i);
    return 10 + par(i);
  endfunction

  // Expected line level at position p of the frame carrying word w.
  function automatic logic exp_bit(int i, logic [7:0] w, int p);
    if (p == 0) return ~idl(i);
    if (p <= 8) return w[p-1];
    if (par(i) == 1 && p == 9) return ^w;
    return idl(i);
  endfunction

  function void check(int i, string name, logic [31:0] act, logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL inst%0d %s: got %0h expected %0h (t=%0t)", i, name, act, exp, $time);
    end
  endfunction

  function automatic int qsize(int i);
    case (i)
      0: return sb0.size();
      1: return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  function automatic logic [7:0] pop(int i);
    case (i)
      0: return sb0.pop_front();
      1: return sb1.pop_front();
      default: return sb2.pop_front();
    endcase
  endfunction

  task automatic push(int i, logic [7:0] w);
    case (i)
      0: sb0.push_back(w);
      1: sb1.push_back(w);
      default: sb2.push_back(w);
    endcase
  endtask

  // Monitor: reset discards everything pending; otherwise follow frames on each line.
  always @(negedge clk) begin
    if (rst) begin
      sb0.delete();
      sb1.delete();
      sb2.delete();
      for (int i = 0; i < 3; i++) pos[i] = -1;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (pos[i] < 0) begin
          if (ser[i] !== idl(i)) begin
            check(i, "start with word pending", (qsize(i) != 0), 1);
            if (qsize(i) != 0) begin
              cur[i] = pop(i);
              pos[i] = 0;
            end
          end else begin
            check(i, "idle done", dn[i], 0);
            if (qsize(i) == 0) begin
              check(i, "idle ready", rdy[i], 1);
              check(i, "idle busy", bsy[i], 0);
            end
          end
        end
        if (pos[i] >= 0) begin
          check(i, $sformatf("bit %0d of %0h", pos[i], cur[i]), ser[i],
                exp_bit(i, cur[i], pos[i]));
          check(i, "done", dn[i], (pos[i] == flen(i) - 1));
          check(i, "frame busy", bsy[i], 1);
          pos[i] = pos[i] + 1;
          if (pos[i] == flen(i)) pos[i] = -1;
        end
      end
    end
  end

  // Present a word from a falling edge and hold it until accepted.
  task automatic send(int i, logic [7:0] w);
    int t;
    t = 0;
    vld[i] = 1'b1;
    din[i] = w;
    while (!rdy[i] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (rdy[i]) push(i, w);
    else check(i, "ready timeout", 0, 1);
    @(negedge clk);
    vld[i] = 1'b0;
  endtask

  task automatic wait_done(int i, output int at);
    at = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dn[i]) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check(i, "done timeout", 0, 1);
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 500 && !ok; c++) begin
      @(negedge clk);
      ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (qsize(i) != 0 || pos[i] >= 0 || bsy[i]) ok = 1'b0;
      end
    end
    check(0, "all frames drained", ok, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic rand_drive(int i);
    int gap;
    for (int n = 0; n < 25; n++) begin
      gap = ($urandom_range(0, 9) < 5) ? 0 : int'($urandom_range(1, 3));
      repeat (gap) @(negedge clk);
      send(i, 8'($urandom));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int at;
    int at2;
    logic quiet;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0;
      din[i] = '0;
      pos[i] = -1;
    end

    // Reset takes effect without a clock edge.
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check(i, "reset ready", rdy[i], 1);
      check(i, "reset busy", bsy[i], 0);
      check(i, "reset done", dn[i], 0);
      check(i, "reset line", ser[i], idl(i));
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 0xA5 from idle: start bit two edges after accept, done on the 10th bit.
    send(0, 8'hA5);
    k = cyc;
    check(0, "busy after accept", bsy[0], 1);
    check(0, "ready after accept", rdy[0], 0);
    check(0, "line k+0", ser[0], 1);
    @(negedge clk);
    check(0, "line k+1", ser[0], 1);
    @(negedge clk);
    check(0, "start bit k+2", ser[0], 0);
    wait_done(0, at);
    check(0, "done cycle offset", at - k, 11);
    @(negedge clk);
    check(0, "busy after frame", bsy[0], 0);
    check(0, "line after frame", ser[0], 1);

    // Parity frame is 11 cycles; inverted idle level frame.
    send(1, 8'h07);
    k = cyc;
    wait_done(1, at);
    check(1, "parity done offset", at - k, 12);
    send(2, 8'hFF);
    drain();
    check(2, "line stays low", ser[2], 0);

    // Back-to-back with valid held: done pulses 10 cycles apart.
    send(0, 8'h01);
    send(0, 8'h80);
    wait_done(0, at);
    @(negedge clk);
    wait_done(0, at2);
    check(0, "back-to-back done spacing", at2 - at, 10);
    drain();

    // Reset during data bit 4 of 0x3C with 0x55 buffered.
    send(0, 8'h3C);
    send(0, 8'h55);
    repeat (5) @(negedge clk);
    check(0, "data bit 4 of 3C", ser[0], 1);
    check(0, "hold full before reset", rdy[0], 0);
    #2 rst = 1'b1;
    #1;
    check(0, "abort line", ser[0], 1);
    check(0, "abort ready", rdy[0], 1);
    check(0, "abort busy", bsy[0], 0);
    check(0, "abort done", dn[0], 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (dn[0] || !ser[0] || bsy[0]) quiet = 1'b0;
    end
    check(0, "no frame after reset", quiet, 1);

    // Randomized traffic with gaps and back-pressure on all three lines.
    fork
      rand_drive(0);
      rand_drive(1);
      rand_drive(2);
    join
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
